// File: rtl/multiplexador_display.sv
// Five-digit common-anode 7-segment scanner fed by the BCD converter.
// It latches the digits on a load strobe and can blank leading zeros.
module multiplexador_display #(
  parameter int DIV_REFRESH = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       carregar,
  input  logic [3:0] dezenaDeMilhar,
  input  logic [3:0] milhar,
  input  logic [3:0] centena,
  input  logic [3:0] dezena,
  input  logic [3:0] unidade,
  input  logic       apagar_zeros,
  output logic [4:0] anodo,
  output logic [6:0] segmentos,
  output logic       quadro_fim
);

  localparam int CNT_W = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;

  logic [4:0][3:0]   dig_q, dig_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [4:0]        anodo_q, anodo_d;
  logic [6:0]        seg_q, seg_d;
  logic              fim_q, fim_d;
  logic              wrap;
  logic              blankSlot;
  logic [4:0]        nonzeroAbove;

  // Segment patterns are ordered g..a and are active low. Non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    dig_d = carregar ? {dezenaDeMilhar, milhar, centena, dezena, unidade} : dig_q;

    wrap  = (cnt_q == CNT_W'(DIV_REFRESH - 1));
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (wrap) idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
    fim_d = wrap && (idx_q == 3'd4);

    // nonzeroAbove[k] is set when any held digit from position k up to 4 is nonzero.
    nonzeroAbove    = '0;
    nonzeroAbove[4] = |dig_q[4];
    for (int k = 3; k >= 0; k--) begin
      nonzeroAbove[k] = nonzeroAbove[k+1] | (|dig_q[k]);
    end
    blankSlot = apagar_zeros && (idx_q != 3'd0) && !nonzeroAbove[idx_q];

    anodo_d = 5'b11111;
    seg_d   = 7'b1111111;
    if (!blankSlot) begin
      anodo_d[idx_q] = 1'b0;
      seg_d          = decode(dig_q[idx_q]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      anodo_q <= 5'b11111;
      seg_q   <= 7'b1111111;
      fim_q   <= 1'b0;
    end else begin
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      anodo_q <= anodo_d;
      seg_q   <= seg_d;
      fim_q   <= fim_d;
    end
  end

  assign anodo      = anodo_q;
  assign segmentos  = seg_q;
  assign quadro_fim = fim_q;

endmodule

// File: tb/tb_multiplexador_display.sv
// Bench for multiplexador_display with DIV_REFRESH=4: a table of digit sets
// scanned over a full frame, plus reset, frame-pulse and mid-slot load sequences.
module tb_multiplexador_display;

   logic       clk;
   logic       rst_n;
   logic       carregar;
   logic [3:0] dezenaDeMilhar, milhar, centena, dezena, unidade;
   logic       apagar_zeros;
   logic [4:0] anodo;
   logic [6:0] segmentos;
   logic       quadro_fim;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      logic [3:0] d4, d3, d2, d1, d0;
      logic       blank;
      logic [6:0] seg [5];
      logic [4:0] lit;
   } vec_t;

   vec_t vecs [7];

   multiplexador_display #(.DIV_REFRESH(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .carregar       (carregar),
      .dezenaDeMilhar (dezenaDeMilhar),
      .milhar         (milhar),
      .centena        (centena),
      .dezena         (dezena),
      .unidade        (unidade),
      .apagar_zeros   (apagar_zeros),
      .anodo          (anodo),
      .segmentos      (segmentos),
      .quadro_fim     (quadro_fim)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, landing 1 ns after the last one.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [6:0] actual, input logic [6:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
   endtask

   task automatic checkOff(input string name);
      checkOutput({name, " anodo"}, {2'b00, anodo}, 7'b0011111);
      checkOutput({name, " segmentos"}, segmentos, 7'b1111111);
      checkOutput({name, " quadro_fim"}, {6'd0, quadro_fim}, 7'd0);
   endtask

   task automatic checkSlot(input string name, input logic [4:0] an, input logic [6:0] sg);
      checkOutput({name, " anodo"}, {2'b00, anodo}, {2'b00, an});
      checkOutput({name, " segmentos"}, segmentos, sg);
   endtask

   // Reset for one edge, then load the digits on the first edge after release (E1).
   task automatic applyStimulus(input logic [3:0] a4, a3, a2, a1, a0, input logic blank);
      rst_n = 1'b0;
      tick(1);
      rst_n          = 1'b1;
      dezenaDeMilhar = a4;
      milhar         = a3;
      centena        = a2;
      dezena         = a1;
      unidade        = a0;
      apagar_zeros   = blank;
      carregar       = 1'b1;
      tick(1);
      carregar = 1'b0;
   endtask

   task automatic setVec(input int i, input logic [3:0] a4, a3, a2, a1, a0, input logic blank,
                         input logic [6:0] s4, s3, s2, s1, s0, input logic [4:0] lit);
      vecs[i].d4 = a4; vecs[i].d3 = a3; vecs[i].d2 = a2; vecs[i].d1 = a1; vecs[i].d0 = a0;
      vecs[i].blank  = blank;
      vecs[i].seg[4] = s4; vecs[i].seg[3] = s3; vecs[i].seg[2] = s2;
      vecs[i].seg[1] = s1; vecs[i].seg[0] = s0;
      vecs[i].lit    = lit;
   endtask

   initial begin
      logic [4:0] expAn;

      setVec(0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 1'b0,
             7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 5'b11111);
      setVec(1, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2, 1'b1,
             7'b1111111, 7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100, 5'b00011);
      setVec(2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1,
             7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000, 5'b00001);
      setVec(3, 4'd0, 4'd0, 4'hA, 4'd0, 4'd0, 1'b1,
             7'b1111111, 7'b1111111, 7'b0111111, 7'b1000000, 7'b1000000, 5'b00111);
      setVec(4, 4'd9, 4'd8, 4'd7, 4'd6, 4'd0, 1'b0,
             7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b1000000, 5'b11111);
      setVec(5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0,
             7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 5'b11111);
      setVec(6, 4'd0, 4'hF, 4'd0, 4'd0, 4'd0, 1'b1,
             7'b1111111, 7'b0111111, 7'b1000000, 7'b1000000, 7'b1000000, 5'b01111);

      rst_n = 1'b0; carregar = 1'b0; apagar_zeros = 1'b0;
      dezenaDeMilhar = 4'd0; milhar = 4'd0; centena = 4'd0; dezena = 4'd0; unidade = 4'd0;
      tick(2);
      checkOff("initial reset");

      // Reset held for three edges in the middle of a scan.
      rst_n = 1'b1;
      tick(6);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         checkOff($sformatf("midscan reset edge %0d", i));
      end
      rst_n = 1'b1;
      tick(1);
      checkSlot("first edge after reset", 5'b11110, 7'b1000000);

      // Each position is lit on edges 4p+1..4p+4 after the load edge; sample at 4p+2.
      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].d4, vecs[v].d3, vecs[v].d2, vecs[v].d1, vecs[v].d0, vecs[v].blank);
         tick(1);
         for (int p = 0; p < 5; p++) begin
            if (p > 0) tick(4);
            expAn = vecs[v].lit[p] ? ~(5'b00001 << p) : 5'b11111;
            checkSlot($sformatf("vec%0d pos%0d", v, p), expAn, vecs[v].seg[p]);
         end
      end

      // Frame pulse follows the wrap 4->0 at edge 20 and then every 20 edges.
      applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 1'b0);
      tick(18);
      checkOutput("fim E19", {6'd0, quadro_fim}, 7'd0);
      tick(1);
      checkOutput("fim E20", {6'd0, quadro_fim}, 7'd1);
      tick(1);
      checkOutput("fim E21", {6'd0, quadro_fim}, 7'd0);
      checkSlot("frame restart E21", 5'b11110, 7'b0010010);
      tick(18);
      checkOutput("fim E39", {6'd0, quadro_fim}, 7'd0);
      tick(1);
      checkOutput("fim E40", {6'd0, quadro_fim}, 7'd1);

      // Reload in the middle of position 3's slot: milhar 4 -> 7.
      applyStimulus(4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 1'b0);
      tick(13);
      checkSlot("midload E14", 5'b10111, 7'b0011001);
      milhar   = 4'd7;
      carregar = 1'b1;
      tick(1);
      carregar = 1'b0;
      checkSlot("midload E15", 5'b10111, 7'b0011001);
      tick(1);
      checkSlot("midload E16", 5'b10111, 7'b1111000);
      tick(1);
      checkSlot("midload E17", 5'b01111, 7'b0010010);

      // One-edge reset while idx=3 clears held digits and restarts at position 0.
      applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 1'b0);
      tick(13);
      checkSlot("pre-reset E14", 5'b10111, 7'b0100100);
      rst_n = 1'b0;
      tick(1);
      checkOff("short reset");
      rst_n = 1'b1;
      tick(1);
      checkSlot("after short reset", 5'b11110, 7'b1000000);
      tick(3);
      checkSlot("after short reset slot end", 5'b11110, 7'b1000000);
      tick(1);
      checkSlot("after short reset pos1", 5'b11101, 7'b1000000);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
